// File: rtl/mult_pkg.sv
// Shared constants and types for the arbitrated Booth multiplier.
package mult_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_GROUP   = 8;
    localparam int DEF_NUM_REQ = 4;

    typedef logic signed [DEF_WIDTH-1:0]   operand_t;
    typedef logic signed [2*DEF_WIDTH-1:0] product_t;

endpackage

// File: rtl/BoothMulti.sv
// Combinational radix-4 Booth signed multiplier, Z = X * Y (two's complement).
// Partial products are summed GROUP bits of Y at a time; WIDTH must be even.
module BoothMulti #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic [WIDTH-1:0]   X,
    input  logic [WIDTH-1:0]   Y,
    output logic [2*WIDTH-1:0] Z
);

    localparam int DIGITS    = WIDTH / 2;
    localparam int PER_GROUP = (GROUP >= 2) ? GROUP / 2 : 1;

    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] pp;
    logic signed [2*WIDTH-1:0] grp;
    logic signed [2*WIDTH-1:0] acc;
    logic [WIDTH:0]            ye;
    logic [2:0]                trip;

    always_comb begin
        xe   = {{WIDTH{X[WIDTH-1]}}, X};
        ye   = {Y, 1'b0};
        acc  = '0;
        grp  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < DIGITS; i++) begin
            // Overlapping 3-bit window selects the Booth digit -2..+2.
            trip = ye[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe <<< 1;
                3'b100:         pp = -(xe <<< 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            grp = grp + (pp <<< (2 * i));
            if (((i + 1) % PER_GROUP == 0) || (i == DIGITS - 1)) begin
                acc = acc + grp;
                grp = '0;
            end
        end
        Z = acc;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, searching from ptr+1.
module rr_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        if (enable && found) begin
            grant[idx] = 1'b1;
        end
    end

    // A grant is only raised when the requester is valid, so it marks a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(NUM_REQ - 1);
        end else if (|grant) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one BoothMulti among NUM_REQ requesters through a 2-stage pipeline
// (operand register A, product register B) with a tagged, backpressured response.
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int GROUP   = DEF_GROUP,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_x,
    input  logic [NUM_REQ*WIDTH-1:0] req_y,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [2*WIDTH-1:0]       resp_z,
    output logic [ID_W-1:0]          resp_id,
    output logic                     busy
);

    logic                 a_valid;
    logic [WIDTH-1:0]     a_x;
    logic [WIDTH-1:0]     a_y;
    logic [ID_W-1:0]      a_id;
    logic                 b_valid;
    logic [2*WIDTH-1:0]   b_z;
    logic [ID_W-1:0]      b_id;
    logic [2*WIDTH-1:0]   mult_z;
    logic                 stall;
    logic                 a_accept;
    logic [NUM_REQ-1:0]   grant;
    logic [ID_W-1:0]      grant_idx;

    assign stall    = b_valid & ~resp_ready;
    assign a_accept = ~a_valid | ~stall;

    // Gating with rst_n keeps req_ready low for the whole reset window.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .enable (a_accept & rst_n),
        .grant  (grant),
        .idx    (grant_idx)
    );

    assign req_ready = grant;

    BoothMulti #(WIDTH, GROUP) u_mult (
        .X (a_x),
        .Y (a_y),
        .Z (mult_z)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_x     <= '0;
            a_y     <= '0;
            a_id    <= '0;
        end else if (a_accept) begin
            a_valid <= |grant;
            if (|grant) begin
                a_x  <= req_x[grant_idx*WIDTH +: WIDTH];
                a_y  <= req_y[grant_idx*WIDTH +: WIDTH];
                a_id <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_z     <= '0;
            b_id    <= '0;
        end else if (!stall) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_z  <= mult_z;
                b_id <= a_id;
            end
        end
    end

    assign resp_valid = b_valid;
    assign resp_z     = b_z;
    assign resp_id    = b_id;
    assign busy       = a_valid | b_valid;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed self-checking bench for mult_arbiter with hand-computed products.
module tb_mult_arbiter;
    import mult_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic             resp_ready;
    logic [2*W-1:0]   resp_z;
    logic [IW-1:0]    resp_id;
    logic             busy;

    int checks;
    int errors;

    mult_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_z     (resp_z),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_z !== 64'h0) begin errors++; $display("FAIL reset_resp_z: got %h expected 0", resp_z); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req_valid = 4'h0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        set_op(0, 32'h0000_0240, 32'h0000_03D2);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        next_cycle();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_z !== 64'h0000_0000_0008_9880) begin errors++; $display("FAIL basic_z: got %h expected 0000000000089880", resp_z); end
        checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d expected 0", resp_id); end
        next_cycle();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy); end
    endtask

    task automatic test_signed();
        logic [W-1:0]   sx [5];
        logic [W-1:0]   sy [5];
        logic [2*W-1:0] sz [5];
        sx[0] = 32'hFFFF_FFFD; sy[0] = 32'h0000_0007; sz[0] = 64'hFFFF_FFFF_FFFF_FFEB;
        sx[1] = 32'h8000_0000; sy[1] = 32'h8000_0000; sz[1] = 64'h4000_0000_0000_0000;
        sx[2] = 32'h0000_0000; sy[2] = 32'hFFFF_FFFF; sz[2] = 64'h0;
        sx[3] = 32'h7FFF_FFFF; sy[3] = 32'h8000_0000; sz[3] = 64'hC000_0000_8000_0000;
        sx[4] = 32'hFFFF_FFFF; sy[4] = 32'hFFFF_FFFF; sz[4] = 64'h0000_0000_0000_0001;
        for (int i = 0; i < 5; i++) begin
            set_op(0, sx[i], sy[i]);
            req_valid = 4'b0001;
            #1;
            checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL signed_ready[%0d]: got %b expected 0001", i, req_ready); end
            next_cycle();
            req_valid = 4'b0000;
            next_cycle();
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL signed_valid[%0d]: got %b expected 1", i, resp_valid); end
            checks++; if (resp_z !== sz[i]) begin errors++; $display("FAIL signed_z[%0d]: got %h expected %h", i, resp_z, sz[i]); end
            next_cycle();
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]   exp_ready;
        logic [IW-1:0]  exp_id;
        logic [2*W-1:0] exp_z;
        apply_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(i + 1), 32'd100);
        resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 10) ? 4'hF : 4'h0;
            #1;
            exp_ready = (c < 10) ? 4'(1 << (c % 4)) : 4'h0;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
            if (c >= 2) begin
                exp_id = 2'((c - 2) % 4);
                exp_z  = 64'((int'(exp_id) + 1) * 100);
                checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", c, resp_valid); end
                checks++; if (resp_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", c, resp_id, exp_id); end
                checks++; if (resp_z !== exp_z) begin errors++; $display("FAIL rr_z[%0d]: got %h expected %h", c, resp_z, exp_z); end
            end
            next_cycle();
        end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        set_op(1, 32'd1, 32'd10);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready0: got %b expected 0010", req_ready); end
        next_cycle();
        set_op(1, 32'd2, 32'd10);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_ready1: got %b expected 0010", req_ready); end
        next_cycle();
        set_op(1, 32'd3, 32'd10);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_full_ready[%0d]: got %b expected 0000", k, req_ready); end
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, resp_valid); end
            checks++; if (resp_z !== 64'd10) begin errors++; $display("FAIL bp_hold_z[%0d]: got %h expected 10", k, resp_z); end
            checks++; if (resp_id !== 2'd1) begin errors++; $display("FAIL bp_hold_id[%0d]: got %0d expected 1", k, resp_id); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b expected 1", k, busy); end
            next_cycle();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b expected 0010", req_ready); end
        checks++; if (resp_z !== 64'd10) begin errors++; $display("FAIL bp_out0: got %h expected 10", resp_z); end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_z !== 64'd20) begin errors++; $display("FAIL bp_out1: got valid=%b z=%h expected valid=1 z=20", resp_valid, resp_z); end
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_z !== 64'd30) begin errors++; $display("FAIL bp_out2: got valid=%b z=%h expected valid=1 z=30", resp_valid, resp_z); end
        next_cycle();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", resp_valid); end
    endtask

    task automatic test_skip();
        logic [N-1:0]   exp_ready;
        logic [IW-1:0]  exp_id;
        logic [2*W-1:0] exp_z;
        set_op(2, 32'd4, 32'd5);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL skip_setup_ready: got %b expected 0100", req_ready); end
        next_cycle();
        req_valid = 4'b0000;
        next_cycle();
        checks++; if (resp_id !== 2'd2 || resp_z !== 64'd20) begin errors++; $display("FAIL skip_setup_resp: got id=%0d z=%h expected id=2 z=20", resp_id, resp_z); end
        next_cycle();
        // Requester 0 raises valid then withdraws it before the edge.
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_drop_ready: got %b expected 0001", req_ready); end
        #1;
        req_valid = 4'b0000;
        next_cycle();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_drop_busy: got %b expected 0", busy); end
        set_op(0, 32'd5, 32'd6);
        set_op(2, 32'hFFFF_FFFE, 32'd9);
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 4) ? 4'b0101 : 4'b0000;
            #1;
            exp_ready = (c >= 4) ? 4'b0000 : ((c % 2 == 0) ? 4'b0001 : 4'b0100);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL skip_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
            if (c >= 2) begin
                exp_id = ((c - 2) % 2 == 0) ? 2'd0 : 2'd2;
                exp_z  = (exp_id == 2'd0) ? 64'd30 : 64'hFFFF_FFFF_FFFF_FFEE;
                checks++; if (resp_valid !== 1'b1 || resp_id !== exp_id) begin errors++; $display("FAIL skip_id[%0d]: got valid=%b id=%0d expected valid=1 id=%0d", c, resp_valid, resp_id, exp_id); end
                checks++; if (resp_z !== exp_z) begin errors++; $display("FAIL skip_z[%0d]: got %h expected %h", c, resp_z, exp_z); end
            end
            next_cycle();
        end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL skip_drain: got %b expected 0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        set_op(3, 32'd7, 32'd7);
        req_valid = 4'b1000;
        next_cycle();
        set_op(3, 32'd8, 32'd7);
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL mid_ready: got %b expected 1000", req_ready); end
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_inflight: got valid=%b busy=%b expected 1 1", resp_valid, busy); end
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", resp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0000", req_ready); end
        req_valid = 4'h0;
        next_cycle();
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b expected 0", k, resp_valid); end
            next_cycle();
        end
        set_op(0, 32'd11, 32'd13);
        req_valid = 4'hF;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready); end
        next_cycle();
        req_valid = 4'h0;
        next_cycle();
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_z !== 64'd143) begin errors++; $display("FAIL mid_after: got valid=%b id=%0d z=%h expected valid=1 id=0 z=8f", resp_valid, resp_id, resp_z); end
        next_cycle();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_signed();
        test_round_robin();
        test_backpressure();
        test_skip();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
